hood_mode_ctrl: RTL and testbench
=================================

# hood_mode_ctrl

Top-level mode sequencer for the range hood. It owns the `mode_state` bus that the self-clean countdown and display blocks decode, and arbitrates the debounced front-panel requests. It enforces the timed modes: 60 s turbo, 60 s post-extract drain and 180 s self-clean. It also exposes the remaining seconds of the active timed mode for display.

## Interface
Parameters:
- `TICK_DIV`, 100_000_000: clk cycles per second; set small, e.g. 10, in simulation.
- `TURBO_S`, 60: turbo duration in seconds.
- `DRAIN_S`, 60: drain duration in seconds.
- `CLEAN_S`, 180: self-clean duration in seconds.

Ports:
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: synchronous, active-high reset.
- `power_en` in 1: level; power switch.
- `menu_pulse` in 1: one-cycle pulse; menu key.
- `lvl1_req`, `lvl2_req`, `lvl3_req` in 1: one-cycle pulses; fan level keys.
- `clean_req` in 1: one-cycle pulse; self-clean key.
- `mode_state` out 3: current mode.
- `fan_level` out 2: 0 = off, 1 to 3 = speed.
- `remain_s` out 8: seconds left in a timed mode; 0 otherwise.
- `turbo_used` out 1: turbo has been consumed in this power session.
- `menu_armed` out 1: menu is open in STANDBY.

## Operation
- Mode encodings:
  - OFF = 3'b000
  - STANDBY = 3'b001
  - EXTRACT = 3'b010
  - TURBO = 3'b011
  - CLEAN = 3'b100
  - DRAIN = 3'b101
- Reset values: OFF, `fan_level` = 0, `remain_s` = 0, `turbo_used` = 0, `menu_armed` = 0, tick counter = 0.
- `power_en` low in any state: the next state is OFF and all outputs take their reset values. This outranks every request.
- OFF: when `power_en` is high, go to STANDBY. `turbo_used` is cleared only in OFF.
- STANDBY:
  - `menu_pulse` toggles `menu_armed`.
  - With `menu_armed` = 1:
    - `lvl1_req` → EXTRACT at level 1.
    - `lvl2_req` → EXTRACT at level 2.
    - `lvl3_req` → TURBO, only if `turbo_used` = 0; otherwise the request is ignored.
    - `clean_req` → CLEAN.
  - `menu_armed` clears on leaving STANDBY.
  - With `menu_armed` = 0, all level and clean requests are ignored.
- EXTRACT:
  - `lvl1_req` / `lvl2_req` set `fan_level` in place.
  - `lvl3_req` → TURBO if `turbo_used` = 0.
  - `menu_pulse` → DRAIN.
  - `clean_req` is ignored.
- TURBO:
  - Entry sets `turbo_used` = 1 and `fan_level` = 3.
  - Expiry → EXTRACT at level 2.
  - `menu_pulse` → DRAIN.
  - Level and clean requests are ignored.
- DRAIN:
  - `fan_level` holds its entry value.
  - Expiry → STANDBY with `fan_level` = 0.
  - All key requests are ignored.
- CLEAN:
  - `fan_level` = 0.
  - Expiry → STANDBY.
  - All key requests are ignored; only `power_en` low or `rst` aborts.
- Same-cycle request priority: `menu_pulse` > `clean_req` > `lvl3_req` > `lvl2_req` > `lvl1_req`. Only the winner is acted on; losers are dropped, not queued.

## Timing
- All outputs are registered. A request sampled in cycle N is reflected in the outputs in cycle N+1.
- Timed-mode entry, in the same edge as the state change:
  - `remain_s` loads N (TURBO_S, DRAIN_S or CLEAN_S).
  - The tick counter loads 0.
- Each cycle in a timed mode the tick counter increments. At `TICK_DIV`-1 it wraps to 0 and `remain_s` decrements.
- Expiry: the wrap tick while `remain_s` = 1. The state changes on that edge and `remain_s` shows the next mode's load value, or 0. Consequences:
  - A timed mode lasts exactly N·`TICK_DIV` cycles.
  - `remain_s` = 0 is never visible inside a timed mode.
- Untimed modes: the tick counter is held at 0 and `remain_s` = 0.
- Re-entering a timed mode, for example TURBO→DRAIN mid-count, reloads both counters; there is no carry-over.
- `rst` mid-countdown: OFF next cycle; the count is discarded.

## Structure
- Package `hood_pkg` holds:
  - the mode encodings listed above, shared with the self-clean and display blocks;
  - the fan-level constants.
- Sub-module `sec_tick`: parameter `TICK_DIV`; inputs `clk`, `rst`, `clr`, `en`; output `tick`, a one-cycle pulse on wrap.
- The FSM and `remain_s` logic stay in `hood_mode_ctrl`. Expected size: about 200 lines of RTL.

## Test plan
All scenarios use `TICK_DIV` = 10.
- Reset with `power_en` = 1: cycle after reset release shows STANDBY, `fan_level` = 0, `remain_s` = 0, `turbo_used` = 0.
- `menu_pulse`, then `lvl3_req`: TURBO with `remain_s` = 60 and `fan_level` = 3. After 600 cycles: EXTRACT, `fan_level` = 2, `turbo_used` = 1. A second TURBO attempt via `lvl3_req` is ignored.
- `menu_pulse`, then `clean_req`: CLEAN with `remain_s` = 180, reading 179 after 10 cycles. STANDBY after exactly 1800 cycles. `lvl1_req` pulses during CLEAN cause no change.
- EXTRACT level 1, then `menu_pulse`: DRAIN with `remain_s` = 60 and `fan_level` = 1; STANDBY after 600 cycles.
- `menu_pulse` and `lvl2_req` in the same cycle in EXTRACT: DRAIN is entered and the level is unchanged.
- `power_en` dropped at `remain_s` = 100 in CLEAN: OFF next cycle with all outputs at reset values. `power_en` restored: STANDBY with `turbo_used` = 0.

Source files
------------

// File: rtl/hood_pkg.sv
// Shared definitions for the range hood: mode encodings decoded by the
// self-clean countdown and display blocks, fan-level constants and key ids.
package hood_pkg;

  typedef enum logic [2:0] {
    MODE_OFF     = 3'b000,
    MODE_STANDBY = 3'b001,
    MODE_EXTRACT = 3'b010,
    MODE_TURBO   = 3'b011,
    MODE_CLEAN   = 3'b100,
    MODE_DRAIN   = 3'b101
  } mode_e;

  localparam logic [1:0] FAN_OFF = 2'd0;
  localparam logic [1:0] FAN_L1  = 2'd1;
  localparam logic [1:0] FAN_L2  = 2'd2;
  localparam logic [1:0] FAN_L3  = 2'd3;

  // Winner of the same-cycle key arbitration.
  typedef enum logic [2:0] {
    KEY_NONE  = 3'd0,
    KEY_MENU  = 3'd1,
    KEY_CLEAN = 3'd2,
    KEY_LVL3  = 3'd3,
    KEY_LVL2  = 3'd4,
    KEY_LVL1  = 3'd5
  } key_e;

  // Modes that run a seconds countdown.
  function automatic logic is_timed(input mode_e m);
    return (m == MODE_TURBO) || (m == MODE_CLEAN) || (m == MODE_DRAIN);
  endfunction

endpackage

// File: rtl/hood_mode_ctrl_sec_tick.sv
// Seconds prescaler: counts clk cycles while enabled and pulses tick for one
// cycle when the count wraps from TICK_DIV-1 back to 0. clr restarts the count.
module sec_tick #(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;

  // Cycle counter; clear wins over counting so a mode entry starts at 0.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/hood_mode_ctrl.sv
// Range hood mode sequencer. Arbitrates the debounced front-panel pulses,
// runs the timed modes (turbo, drain, self-clean) and reports remaining
// seconds. Key inputs are fire-and-forget one-cycle pulses: there is no
// ready/back-pressure, a pulse that is not acted on in its cycle is dropped.
// mode_state is the FSM state register itself, so checkers can bind to it.
module hood_mode_ctrl
  import hood_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int TURBO_S  = 60,
  parameter int DRAIN_S  = 60,
  parameter int CLEAN_S  = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       power_en,
  input  logic       menu_pulse,
  input  logic       lvl1_req,
  input  logic       lvl2_req,
  input  logic       lvl3_req,
  input  logic       clean_req,
  output logic [2:0] mode_state,
  output logic [1:0] fan_level,
  output logic [7:0] remain_s,
  output logic       turbo_used,
  output logic       menu_armed
);

  localparam logic [7:0] TURBO_L = 8'(TURBO_S);
  localparam logic [7:0] DRAIN_L = 8'(DRAIN_S);
  localparam logic [7:0] CLEAN_L = 8'(CLEAN_S);

  mode_e      state_q, state_nx;
  logic [1:0] fan_q, fan_nx;
  logic [7:0] remain_q, remain_nx;
  logic       turbo_q, turbo_nx;
  logic       menu_q, menu_nx;
  key_e       key_win;
  logic       tick;
  logic       expire;
  logic       tick_clr;

  // Prescaler restarts on every mode change and idles outside timed modes,
  // so re-entering a timed mode never inherits a partial second.
  assign tick_clr = (state_nx != state_q) || !is_timed(state_nx);

  sec_tick #(.TICK_DIV(TICK_DIV)) u_sec_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (tick_clr),
    .en   (is_timed(state_q)),
    .tick (tick)
  );

  // Last second wrapping ends the timed mode on this edge.
  assign expire = tick && (remain_q == 8'd1);

  // Fixed-priority key arbitration; losers are dropped.
  always_comb begin
    key_win = KEY_NONE;
    if (menu_pulse)     key_win = KEY_MENU;
    else if (clean_req) key_win = KEY_CLEAN;
    else if (lvl3_req)  key_win = KEY_LVL3;
    else if (lvl2_req)  key_win = KEY_LVL2;
    else if (lvl1_req)  key_win = KEY_LVL1;
  end

  // Registered mode and output state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MODE_OFF;
      fan_q    <= FAN_OFF;
      remain_q <= 8'd0;
      turbo_q  <= 1'b0;
      menu_q   <= 1'b0;
    end else begin
      state_q  <= state_nx;
      fan_q    <= fan_nx;
      remain_q <= remain_nx;
      turbo_q  <= turbo_nx;
      menu_q   <= menu_nx;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_nx  = state_q;
    fan_nx    = fan_q;
    remain_nx = remain_q;
    turbo_nx  = turbo_q;
    menu_nx   = 1'b0;

    if (!power_en) begin
      state_nx  = MODE_OFF;
      fan_nx    = FAN_OFF;
      remain_nx = 8'd0;
      turbo_nx  = 1'b0;
    end else begin
      // Countdown in timed modes; overridden below on expiry or re-entry.
      if (is_timed(state_q) && tick) remain_nx = remain_q - 8'd1;

      case (state_q)
        MODE_OFF: begin
          state_nx  = MODE_STANDBY;
          fan_nx    = FAN_OFF;
          remain_nx = 8'd0;
          turbo_nx  = 1'b0;
        end

        MODE_STANDBY: begin
          menu_nx   = menu_q;
          remain_nx = 8'd0;
          fan_nx    = FAN_OFF;
          if (key_win == KEY_MENU) begin
            menu_nx = !menu_q;
          end else if (menu_q) begin
            case (key_win)
              KEY_CLEAN: begin
                state_nx  = MODE_CLEAN;
                remain_nx = CLEAN_L;
                menu_nx   = 1'b0;
              end
              KEY_LVL3: begin
                if (!turbo_q) begin
                  state_nx  = MODE_TURBO;
                  fan_nx    = FAN_L3;
                  remain_nx = TURBO_L;
                  turbo_nx  = 1'b1;
                  menu_nx   = 1'b0;
                end
              end
              KEY_LVL2: begin
                state_nx = MODE_EXTRACT;
                fan_nx   = FAN_L2;
                menu_nx  = 1'b0;
              end
              KEY_LVL1: begin
                state_nx = MODE_EXTRACT;
                fan_nx   = FAN_L1;
                menu_nx  = 1'b0;
              end
              default: ;
            endcase
          end
        end

        MODE_EXTRACT: begin
          remain_nx = 8'd0;
          case (key_win)
            KEY_MENU: begin
              state_nx  = MODE_DRAIN;
              remain_nx = DRAIN_L;
            end
            KEY_LVL3: begin
              if (!turbo_q) begin
                state_nx  = MODE_TURBO;
                fan_nx    = FAN_L3;
                remain_nx = TURBO_L;
                turbo_nx  = 1'b1;
              end
            end
            KEY_LVL2: fan_nx = FAN_L2;
            KEY_LVL1: fan_nx = FAN_L1;
            default: ;
          endcase
        end

        MODE_TURBO: begin
          if (key_win == KEY_MENU) begin
            state_nx  = MODE_DRAIN;
            remain_nx = DRAIN_L;
          end else if (expire) begin
            state_nx  = MODE_EXTRACT;
            fan_nx    = FAN_L2;
            remain_nx = 8'd0;
          end
        end

        MODE_DRAIN: begin
          if (expire) begin
            state_nx  = MODE_STANDBY;
            fan_nx    = FAN_OFF;
            remain_nx = 8'd0;
          end
        end

        MODE_CLEAN: begin
          fan_nx = FAN_OFF;
          if (expire) begin
            state_nx  = MODE_STANDBY;
            remain_nx = 8'd0;
          end
        end

        default: begin
          state_nx  = MODE_OFF;
          fan_nx    = FAN_OFF;
          remain_nx = 8'd0;
          turbo_nx  = 1'b0;
        end
      endcase
    end
  end

  assign mode_state = state_q;
  assign fan_level  = fan_q;
  assign remain_s   = remain_q;
  assign turbo_used = turbo_q;
  assign menu_armed = menu_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Directed testbench for hood_mode_ctrl with TICK_DIV = 10.
// Outputs are packed as {mode(3), fan(2), remain(8), turbo_used, menu_armed}.
module tb_hood_mode_ctrl;

  localparam logic [2:0] M_OFF = 3'b000;
  localparam logic [2:0] M_SB  = 3'b001;
  localparam logic [2:0] M_EX  = 3'b010;
  localparam logic [2:0] M_TU  = 3'b011;
  localparam logic [2:0] M_CL  = 3'b100;
  localparam logic [2:0] M_DR  = 3'b101;

  // Key vector order: {menu, clean, lvl3, lvl2, lvl1}
  localparam logic [4:0] K_MENU  = 5'b10000;
  localparam logic [4:0] K_CLEAN = 5'b01000;
  localparam logic [4:0] K_L3    = 5'b00100;
  localparam logic [4:0] K_L2    = 5'b00010;
  localparam logic [4:0] K_L1    = 5'b00001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       power_en = 1'b1;
  logic       menu_pulse = 1'b0;
  logic       lvl1_req = 1'b0;
  logic       lvl2_req = 1'b0;
  logic       lvl3_req = 1'b0;
  logic       clean_req = 1'b0;
  logic [2:0] mode_state;
  logic [1:0] fan_level;
  logic [7:0] remain_s;
  logic       turbo_used;
  logic       menu_armed;
  logic [14:0] snap;

  int checks = 0;
  int failures = 0;

  hood_mode_ctrl #(
    .TICK_DIV(10), .TURBO_S(60), .DRAIN_S(60), .CLEAN_S(180)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .power_en   (power_en),
    .menu_pulse (menu_pulse),
    .lvl1_req   (lvl1_req),
    .lvl2_req   (lvl2_req),
    .lvl3_req   (lvl3_req),
    .clean_req  (clean_req),
    .mode_state (mode_state),
    .fan_level  (fan_level),
    .remain_s   (remain_s),
    .turbo_used (turbo_used),
    .menu_armed (menu_armed)
  );

  // Clock
  always #5 clk = ~clk;

  assign snap = {mode_state, fan_level, remain_s, turbo_used, menu_armed};

  // Drivers: inputs change 1 ns after a rising edge; outputs sampled there too.
  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [4:0] k);
    {menu_pulse, clean_req, lvl3_req, lvl2_req, lvl1_req} = k;
    @(posedge clk);
    #1;
    {menu_pulse, clean_req, lvl3_req, lvl2_req, lvl1_req} = 5'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    power_en = 1'b1;
    wait_cycles(3);
    checks++;
    if (snap !== {M_OFF, 2'd0, 8'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL reset_held got=%h exp=%h", snap, {M_OFF, 2'd0, 8'd0, 1'b0, 1'b0});
    end
    rst = 1'b0;
    wait_cycles(1);
    checks++;
    if (snap !== {M_SB, 2'd0, 8'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL reset_release got=%h exp=%h", snap, {M_SB, 2'd0, 8'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_turbo();
    press(K_MENU);
    checks++;
    if (snap !== {M_SB, 2'd0, 8'd0, 1'b0, 1'b1}) begin
      failures++; $display("FAIL menu_arm got=%h exp=%h", snap, {M_SB, 2'd0, 8'd0, 1'b0, 1'b1});
    end
    press(K_L3);
    checks++;
    if (snap !== {M_TU, 2'd3, 8'd60, 1'b1, 1'b0}) begin
      failures++; $display("FAIL turbo_entry got=%h exp=%h", snap, {M_TU, 2'd3, 8'd60, 1'b1, 1'b0});
    end
    wait_cycles(10);
    checks++;
    if (snap !== {M_TU, 2'd3, 8'd59, 1'b1, 1'b0}) begin
      failures++; $display("FAIL turbo_first_sec got=%h exp=%h", snap, {M_TU, 2'd3, 8'd59, 1'b1, 1'b0});
    end
    wait_cycles(589);
    checks++;
    if (snap !== {M_TU, 2'd3, 8'd1, 1'b1, 1'b0}) begin
      failures++; $display("FAIL turbo_last_cycle got=%h exp=%h", snap, {M_TU, 2'd3, 8'd1, 1'b1, 1'b0});
    end
    wait_cycles(1);
    checks++;
    if (snap !== {M_EX, 2'd2, 8'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL turbo_expiry got=%h exp=%h", snap, {M_EX, 2'd2, 8'd0, 1'b1, 1'b0});
    end
    press(K_L3);
    checks++;
    if (snap !== {M_EX, 2'd2, 8'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL turbo_reuse got=%h exp=%h", snap, {M_EX, 2'd2, 8'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    // menu and lvl2 together in EXTRACT: menu wins, level untouched
    press(K_MENU | K_L2 | K_L1);
    checks++;
    if (snap !== {M_DR, 2'd2, 8'd60, 1'b1, 1'b0}) begin
      failures++; $display("FAIL menu_lvl2_same_cycle got=%h exp=%h", snap, {M_DR, 2'd2, 8'd60, 1'b1, 1'b0});
    end
    wait_cycles(600);
    checks++;
    if (snap !== {M_SB, 2'd0, 8'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL drain2_expiry got=%h exp=%h", snap, {M_SB, 2'd0, 8'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_clean();
    press(K_MENU);
    press(K_CLEAN);
    checks++;
    if (snap !== {M_CL, 2'd0, 8'd180, 1'b1, 1'b0}) begin
      failures++; $display("FAIL clean_entry got=%h exp=%h", snap, {M_CL, 2'd0, 8'd180, 1'b1, 1'b0});
    end
    wait_cycles(10);
    checks++;
    if (snap !== {M_CL, 2'd0, 8'd179, 1'b1, 1'b0}) begin
      failures++; $display("FAIL clean_first_sec got=%h exp=%h", snap, {M_CL, 2'd0, 8'd179, 1'b1, 1'b0});
    end
    press(K_L1);
    checks++;
    if (snap !== {M_CL, 2'd0, 8'd179, 1'b1, 1'b0}) begin
      failures++; $display("FAIL clean_ignores_lvl1 got=%h exp=%h", snap, {M_CL, 2'd0, 8'd179, 1'b1, 1'b0});
    end
    press(K_MENU);
    checks++;
    if (snap !== {M_CL, 2'd0, 8'd179, 1'b1, 1'b0}) begin
      failures++; $display("FAIL clean_ignores_menu got=%h exp=%h", snap, {M_CL, 2'd0, 8'd179, 1'b1, 1'b0});
    end
    wait_cycles(1787);
    checks++;
    if (snap !== {M_CL, 2'd0, 8'd1, 1'b1, 1'b0}) begin
      failures++; $display("FAIL clean_last_cycle got=%h exp=%h", snap, {M_CL, 2'd0, 8'd1, 1'b1, 1'b0});
    end
    wait_cycles(1);
    checks++;
    if (snap !== {M_SB, 2'd0, 8'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL clean_expiry got=%h exp=%h", snap, {M_SB, 2'd0, 8'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_drain();
    press(K_MENU);
    press(K_L1);
    checks++;
    if (snap !== {M_EX, 2'd1, 8'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL extract_l1 got=%h exp=%h", snap, {M_EX, 2'd1, 8'd0, 1'b1, 1'b0});
    end
    press(K_L2);
    checks++;
    if (snap !== {M_EX, 2'd2, 8'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL extract_set_l2 got=%h exp=%h", snap, {M_EX, 2'd2, 8'd0, 1'b1, 1'b0});
    end
    press(K_L1);
    press(K_CLEAN);
    checks++;
    if (snap !== {M_EX, 2'd1, 8'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL extract_l1_clean_ignored got=%h exp=%h", snap, {M_EX, 2'd1, 8'd0, 1'b1, 1'b0});
    end
    press(K_MENU);
    checks++;
    if (snap !== {M_DR, 2'd1, 8'd60, 1'b1, 1'b0}) begin
      failures++; $display("FAIL drain_entry got=%h exp=%h", snap, {M_DR, 2'd1, 8'd60, 1'b1, 1'b0});
    end
    wait_cycles(599);
    checks++;
    if (snap !== {M_DR, 2'd1, 8'd1, 1'b1, 1'b0}) begin
      failures++; $display("FAIL drain_last_cycle got=%h exp=%h", snap, {M_DR, 2'd1, 8'd1, 1'b1, 1'b0});
    end
    wait_cycles(1);
    checks++;
    if (snap !== {M_SB, 2'd0, 8'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL drain_expiry got=%h exp=%h", snap, {M_SB, 2'd0, 8'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_priority();
    press(K_MENU);
    press(K_MENU | K_L1);
    checks++;
    if (snap !== {M_SB, 2'd0, 8'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL menu_beats_lvl1 got=%h exp=%h", snap, {M_SB, 2'd0, 8'd0, 1'b1, 1'b0});
    end
    press(K_L2);
    checks++;
    if (snap !== {M_SB, 2'd0, 8'd0, 1'b1, 1'b0}) begin
      failures++; $display("FAIL unarmed_lvl2 got=%h exp=%h", snap, {M_SB, 2'd0, 8'd0, 1'b1, 1'b0});
    end
    press(K_MENU);
    press(K_L3);
    checks++;
    if (snap !== {M_SB, 2'd0, 8'd0, 1'b1, 1'b1}) begin
      failures++; $display("FAIL standby_turbo_used got=%h exp=%h", snap, {M_SB, 2'd0, 8'd0, 1'b1, 1'b1});
    end
    press(K_CLEAN | K_L3 | K_L1);
    checks++;
    if (snap !== {M_CL, 2'd0, 8'd180, 1'b1, 1'b0}) begin
      failures++; $display("FAIL clean_beats_levels got=%h exp=%h", snap, {M_CL, 2'd0, 8'd180, 1'b1, 1'b0});
    end
  endtask

  task automatic test_power_drop();
    wait_cycles(800);
    checks++;
    if (snap !== {M_CL, 2'd0, 8'd100, 1'b1, 1'b0}) begin
      failures++; $display("FAIL clean_at_100 got=%h exp=%h", snap, {M_CL, 2'd0, 8'd100, 1'b1, 1'b0});
    end
    power_en = 1'b0;
    wait_cycles(1);
    checks++;
    if (snap !== {M_OFF, 2'd0, 8'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL power_drop got=%h exp=%h", snap, {M_OFF, 2'd0, 8'd0, 1'b0, 1'b0});
    end
    press(K_MENU | K_L1);
    checks++;
    if (snap !== {M_OFF, 2'd0, 8'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL power_low_keys got=%h exp=%h", snap, {M_OFF, 2'd0, 8'd0, 1'b0, 1'b0});
    end
    power_en = 1'b1;
    wait_cycles(1);
    checks++;
    if (snap !== {M_SB, 2'd0, 8'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL power_restore got=%h exp=%h", snap, {M_SB, 2'd0, 8'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_reload_and_rst();
    press(K_MENU);
    press(K_L3);
    checks++;
    if (snap !== {M_TU, 2'd3, 8'd60, 1'b1, 1'b0}) begin
      failures++; $display("FAIL turbo_again got=%h exp=%h", snap, {M_TU, 2'd3, 8'd60, 1'b1, 1'b0});
    end
    wait_cycles(25);
    checks++;
    if (snap !== {M_TU, 2'd3, 8'd58, 1'b1, 1'b0}) begin
      failures++; $display("FAIL turbo_mid got=%h exp=%h", snap, {M_TU, 2'd3, 8'd58, 1'b1, 1'b0});
    end
    press(K_MENU);
    checks++;
    if (snap !== {M_DR, 2'd3, 8'd60, 1'b1, 1'b0}) begin
      failures++; $display("FAIL turbo_to_drain got=%h exp=%h", snap, {M_DR, 2'd3, 8'd60, 1'b1, 1'b0});
    end
    wait_cycles(9);
    checks++;
    if (snap !== {M_DR, 2'd3, 8'd60, 1'b1, 1'b0}) begin
      failures++; $display("FAIL drain_no_carry got=%h exp=%h", snap, {M_DR, 2'd3, 8'd60, 1'b1, 1'b0});
    end
    wait_cycles(1);
    checks++;
    if (snap !== {M_DR, 2'd3, 8'd59, 1'b1, 1'b0}) begin
      failures++; $display("FAIL drain_first_sec got=%h exp=%h", snap, {M_DR, 2'd3, 8'd59, 1'b1, 1'b0});
    end
    rst = 1'b1;
    wait_cycles(1);
    checks++;
    if (snap !== {M_OFF, 2'd0, 8'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL rst_mid_count got=%h exp=%h", snap, {M_OFF, 2'd0, 8'd0, 1'b0, 1'b0});
    end
    rst = 1'b0;
    wait_cycles(1);
    checks++;
    if (snap !== {M_SB, 2'd0, 8'd0, 1'b0, 1'b0}) begin
      failures++; $display("FAIL rst_release got=%h exp=%h", snap, {M_SB, 2'd0, 8'd0, 1'b0, 1'b0});
    end
  endtask

  initial begin
    test_reset();
    test_turbo();
    test_back_to_back();
    test_clean();
    test_drain();
    test_priority();
    test_power_drop();
    test_reload_and_rst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
